// File: rtl/yarvi_imem_ctl.sv
// Code-memory controller: registered-read instruction fetch into a 2-entry queue,
// sharing the single synchronous RAM port with a data-side load/store requester.
module yarvi_imem_ctl #(
  parameter int              VA_W      = 32,
  parameter int              IDX_W     = 12,
  parameter logic [VA_W-1:0] CODE_BASE = 32'h80000000,
  parameter logic [VA_W-1:0] INIT_PC   = 32'h80000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic [VA_W-1:0]  restart_pc,
  input  logic             dq_valid,
  output logic             dq_ready,
  input  logic             dq_write,
  input  logic [VA_W-1:0]  dq_addr,
  input  logic [31:0]      dq_wdata,
  input  logic [3:0]       dq_wmask,
  output logic             dr_valid,
  output logic [31:0]      dr_data,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             fe_valid,
  input  logic             fe_ready,
  output logic [VA_W-1:0]  fe_pc,
  output logic [31:0]      fe_insn
);

  logic [VA_W-1:0] pc_q, pc_d;
  logic [VA_W-1:0] q_pc_q [2];
  logic [VA_W-1:0] q_pc_d [2];
  logic [31:0]     q_insn_q [2];
  logic [31:0]     q_insn_d [2];
  logic [1:0]      count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [VA_W-1:0] infl_pc_q, infl_pc_d;
  logic            ld_pend_q, ld_pend_d;
  logic            ld_zero_q, ld_zero_d;
  logic [1:0]      starve_q, starve_d;

  logic       pop, eligible, force_fetch, data_grant, fetch_grant, in_region;
  logic [2:0] occ;
  logic       unused_bits;

  assign unused_bits = ^{restart_pc[1:0], dq_addr[1:0]};

  assign in_region   = (dq_addr[VA_W-1:IDX_W+2] == CODE_BASE[VA_W-1:IDX_W+2]);
  assign fe_valid    = !reset && (count_q != 2'd0);
  assign pop         = fe_valid && fe_ready;
  assign occ         = {1'b0, count_q} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop may be reused by an issue in the same cycle.
  assign eligible    = !restart && ((occ < 3'd2) || ((occ == 3'd2) && pop));
  assign force_fetch = (starve_q == 2'd3);
  assign data_grant  = !reset && dq_valid && !force_fetch;
  assign fetch_grant = !reset && eligible && !data_grant;

  assign dq_ready = data_grant;
  assign dr_valid = !reset && ld_pend_q;
  assign dr_data  = ld_zero_q ? 32'h0 : mem_rdata;
  assign fe_pc    = q_pc_q[0];
  assign fe_insn  = q_insn_q[0];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = pc_q[IDX_W+1:2];
    mem_wdata = dq_wdata;
    if (data_grant) begin
      mem_addr = dq_addr[IDX_W+1:2];
      mem_en   = in_region;
      if (dq_write && in_region) mem_we = dq_wmask;
    end else if (fetch_grant) begin
      mem_en = 1'b1;
    end
  end

  always_comb begin
    q_pc_d   = q_pc_q;
    q_insn_d = q_insn_q;
    count_d  = count_q;
    if (pop) begin
      q_pc_d[0]   = q_pc_q[1];
      q_insn_d[0] = q_insn_q[1];
      count_d     = count_q - 2'd1;
    end
    if (inflight_q) begin
      if (count_d == 2'd0) begin
        q_pc_d[0]   = infl_pc_q;
        q_insn_d[0] = mem_rdata;
      end else begin
        q_pc_d[1]   = infl_pc_q;
        q_insn_d[1] = mem_rdata;
      end
      count_d = count_d + 2'd1;
    end
    // Restart flushes the queue and kills the response returning this cycle.
    if (restart) count_d = 2'd0;
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = fetch_grant;
    infl_pc_d  = pc_q;
    ld_pend_d  = data_grant && !dq_write;
    ld_zero_d  = !in_region;
    starve_d   = starve_q;
    if (restart) pc_d = {restart_pc[VA_W-1:2], 2'b00};
    else if (fetch_grant) pc_d = pc_q + VA_W'(4);
    if (fetch_grant || !eligible) starve_d = 2'd0;
    else if (data_grant && (starve_q != 2'd3)) starve_d = starve_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= INIT_PC;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      infl_pc_q   <= '0;
      ld_pend_q   <= 1'b0;
      ld_zero_q   <= 1'b0;
      starve_q    <= 2'd0;
      q_pc_q[0]   <= '0;
      q_pc_q[1]   <= '0;
      q_insn_q[0] <= '0;
      q_insn_q[1] <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      ld_pend_q  <= ld_pend_d;
      ld_zero_q  <= ld_zero_d;
      starve_q   <= starve_d;
      q_pc_q     <= q_pc_d;
      q_insn_q   <= q_insn_d;
    end
  end

endmodule
